// File: rtl/mul_prod_accumulator_pkg.sv
// rtl/mul_prod_accumulator_pkg.sv - shared constants and FSM states for the product accumulator
package mul_prod_accumulator_pkg;

    // Product width of the upstream 4-bit sequential multiplier.
    localparam int MUL_PROD_W = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/mul_prod_accumulator_if.sv
// rtl/mul_prod_accumulator_if.sv - product input / frame sum output handshake bundle
interface mul_prod_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 2
);
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic              clear;
    logic [ACC_W-1:0]  sum_out;
    logic              sum_valid;
    logic              sum_ready;
    logic              overflow;
    logic [CNT_W-1:0]  prod_cnt;

    modport master (
        output prod_in, prod_valid, clear, sum_ready,
        input  prod_ready, sum_out, sum_valid, overflow, prod_cnt
    );

    modport slave (
        input  prod_in, prod_valid, clear, sum_ready,
        output prod_ready, sum_out, sum_valid, overflow, prod_cnt
    );
endinterface

// File: rtl/mul_prod_accumulator_add_carry.sv
// rtl/mul_prod_accumulator_add_carry.sv - accumulator adder exposing carry out of ACC_W
module acc_add_carry #(
    parameter int ACC_W  = 10,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    assign {carry, sum} = {1'b0, a} + (ACC_W + 1)'(b);
endmodule

// File: rtl/mul_prod_accumulator.sv
// rtl/mul_prod_accumulator.sv - sums FRAME_LEN products and holds each frame sum until consumed
module mul_prod_accumulator
    import mul_prod_accumulator_pkg::*;
#(
    parameter int PROD_W    = MUL_PROD_W,
    parameter int ACC_W     = 10,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_prod_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    acc_state_t       state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             accept;
    logic             last;
    logic             consume;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    acc_add_carry #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .a     (acc),
        .b     (bus.prod_in),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    // clear outranks both accept and sum_ready.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        consume   = 1'b0;
        last      = (cnt == LAST_CNT);
        case (state)
            ST_ACCUM: begin
                accept = bus.prod_valid & ~bus.clear;
                if (accept && last) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                consume = bus.sum_ready & ~bus.clear;
                if (consume) state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
        if (bus.clear) state_nxt = ST_ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            sum_q <= '0;
            ovf   <= 1'b0;
        end else if (bus.clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= ovf | add_carry;
            if (last) begin
                sum_q <= add_sum;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                acc <= add_sum;
                cnt <= cnt + 1'b1;
            end
        end else if (consume) begin
            ovf <= 1'b0;
        end
    end

    assign bus.prod_ready = (state == ST_ACCUM);
    assign bus.sum_valid  = (state == ST_HOLD);
    assign bus.sum_out    = sum_q;
    assign bus.overflow   = ovf;
    assign bus.prod_cnt   = cnt;
endmodule

// File: tb/tb_mul_prod_accumulator.sv
// tb/tb_mul_prod_accumulator.sv - scoreboard bench for three accumulator configurations
module tb_mul_prod_accumulator;
    localparam int NI = 3;
    localparam int W [NI] = '{10, 9, 10};
    localparam int L [NI] = '{4, 4, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p;
    logic       v, c, sr;

    always #5 clk = ~clk;

    mul_prod_accumulator_if #(.PROD_W(8), .ACC_W(10), .CNT_W(2)) if0 ();
    mul_prod_accumulator_if #(.PROD_W(8), .ACC_W(9),  .CNT_W(2)) if1 ();
    mul_prod_accumulator_if #(.PROD_W(8), .ACC_W(10), .CNT_W(1)) if2 ();

    assign if0.prod_in = p;  assign if0.prod_valid = v;  assign if0.clear = c;  assign if0.sum_ready = sr;
    assign if1.prod_in = p;  assign if1.prod_valid = v;  assign if1.clear = c;  assign if1.sum_ready = sr;
    assign if2.prod_in = p;  assign if2.prod_valid = v;  assign if2.clear = c;  assign if2.sum_ready = sr;

    mul_prod_accumulator #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(4), .CNT_W(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mul_prod_accumulator #(.PROD_W(8), .ACC_W(9),  .FRAME_LEN(4), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mul_prod_accumulator #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(1), .CNT_W(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [9:0] d_sum [NI];
    logic [1:0] d_cnt [NI];
    logic       d_rdy [NI];
    logic       d_vld [NI];
    logic       d_ovf [NI];

    assign d_sum[0] = if0.sum_out;          assign d_sum[1] = {1'b0, if1.sum_out};  assign d_sum[2] = if2.sum_out;
    assign d_cnt[0] = if0.prod_cnt;         assign d_cnt[1] = if1.prod_cnt;         assign d_cnt[2] = {1'b0, if2.prod_cnt};
    assign d_rdy[0] = if0.prod_ready;       assign d_rdy[1] = if1.prod_ready;       assign d_rdy[2] = if2.prod_ready;
    assign d_vld[0] = if0.sum_valid;        assign d_vld[1] = if1.sum_valid;        assign d_vld[2] = if2.sum_valid;
    assign d_ovf[0] = if0.overflow;         assign d_ovf[1] = if1.overflow;         assign d_ovf[2] = if2.overflow;

    // Reference model: a frame is a running total; its sum is total mod 2**W, overflow is total >= 2**W.
    bit hold  [NI];
    int fsum  [NI];
    int fn    [NI];
    int lsum  [NI];
    bit hovf  [NI];
    int exp_q [NI][$];

    typedef struct {
        int k;
        bit rdy;
        int cnt;
        bit vld;
        int sum;
        bit ovf;
    } stat_t;
    stat_t sq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic cyc(input int pi, input bit vi, input bit ci, input bit sri, input bit rsti);
        stat_t s;
        p = pi[7:0]; v = vi; c = ci; sr = sri; rst = rsti;
        for (int k = 0; k < NI; k++) begin
            s.k   = k;
            s.rdy = !hold[k];
            s.cnt = fn[k];
            s.vld = hold[k];
            s.sum = lsum[k];
            s.ovf = hold[k] ? hovf[k] : (fsum[k] >= (1 << W[k]));
            sq.push_back(s);
            if (rsti) begin
                if (hold[k]) void'(exp_q[k].pop_back());
                hold[k] = 0; fsum[k] = 0; fn[k] = 0; lsum[k] = 0; hovf[k] = 0;
            end else if (ci) begin
                if (hold[k]) void'(exp_q[k].pop_back());
                hold[k] = 0; fsum[k] = 0; fn[k] = 0;
            end else if (hold[k]) begin
                if (sri) hold[k] = 0;
            end else if (vi) begin
                fsum[k] += pi;
                fn[k]++;
                if (fn[k] == L[k]) begin
                    lsum[k] = fsum[k] % (1 << W[k]);
                    hovf[k] = (fsum[k] >= (1 << W[k]));
                    exp_q[k].push_back(lsum[k] * 2 + int'(hovf[k]));
                    hold[k] = 1; fsum[k] = 0; fn[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        stat_t s;
        int e;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            chk("prod_ready", s.k, int'(d_rdy[s.k]), int'(s.rdy));
            chk("prod_cnt",   s.k, int'(d_cnt[s.k]), s.cnt);
            chk("sum_valid",  s.k, int'(d_vld[s.k]), int'(s.vld));
            chk("sum_out",    s.k, int'(d_sum[s.k]), s.sum);
            chk("overflow",   s.k, int'(d_ovf[s.k]), int'(s.ovf));
        end
        for (int k = 0; k < NI; k++) begin
            if (d_vld[k] === 1'b1 && sr === 1'b1 && c === 1'b0 && rst === 1'b0) begin
                if (exp_q[k].size() == 0) begin
                    chk("spurious_sum", k, 1, 0);
                end else begin
                    e = exp_q[k].pop_front();
                    chk("frame_sum", k, int'(d_sum[k]), e / 2);
                    chk("frame_ovf", k, int'(d_ovf[k]), e % 2);
                end
            end
        end
    end

    initial begin
        p = '0; v = 1'b0; c = 1'b0; sr = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0);
        // 225 x4: 900 fits ACC_W=10, wraps to 388 with overflow at ACC_W=9
        for (int i = 0; i < 4; i++) cyc(225, 1, 0, 0, 0);
        repeat (5) cyc(7, 1, 0, 0, 0);
        cyc(7, 1, 0, 1, 0);
        cyc(7, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(3, 1, 0, 0, 0);
        cyc(5, 1, 0, 0, 0);
        cyc(9, 1, 1, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(i, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(225, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(42, 1, 0, 0, 0);
        cyc(43, 1, 0, 1, 0);
        cyc(43, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 255), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk("unconsumed_sums", k, exp_q[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
